countdown_timer: RTL
====================

Name: countdown_timer

Overview:
- Count-down companion to the team's up-counting stopwatch.
- Loads a preset and decrements once per clock while running.
- Flags expiry with a one-cycle pulse and an optional auto-reload.
- Used as the timeout/interval source beside the stopwatch. The count output has the same width and MAX clamp convention as the stopwatch, so the two are interchangeable on a shared display path.

Parameters:
- DATA_WIDTH, 16, width of count, load_value and internal reload register.
- MAX, 99, largest legal count; larger load values clamp to MAX.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  capture load_value into count and reload register.
- load_value  input  DATA_WIDTH  preset to load.
- start  input  1  begin or resume decrementing.
- stop  input  1  pause; count holds.
- auto_reload  input  1  at expiry, reload preset and keep running instead of stopping.
- count  output  DATA_WIDTH  current remaining count (registered).
- running  output  1  high while in RUN state.
- expired  output  1  one-cycle pulse on expiry.
- done  output  1  level, high in DONE state.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high on port reset.
- Reset values: count=0, reload_reg=0, state=IDLE, running=0, expired=0, done=0.
- States: IDLE (paused or never started), RUN (decrementing), DONE (expired, no auto-reload).
- Priority per cycle: reset > load > stop > start.
- load:
  - count and reload_reg <= min(load_value, MAX); state <= IDLE; expired <= 0.
  - Applies from any state, including mid-RUN.
  - Overrides start/stop in the same cycle.
- stop: state <= IDLE, count holds, expired <= 0. Stop wins over a simultaneous start.
- start in IDLE with count>0: state <= RUN, and count decrements in that same edge, so there is no dead cycle. This matches the stopwatch (start && running behaves as running).
- start with count==0 (IDLE or DONE): ignored; state unchanged, no pulse.
- start while already RUN: no effect beyond continuing.
- RUN, count>1: count <= count-1.
- RUN, count==1, auto_reload=0: count <= 0, state <= DONE, expired <= 1 for exactly that cycle.
- RUN, count==1, auto_reload=1: count <= reload_reg, state stays RUN, expired <= 1 for that cycle. In this case count never shows 0.
- auto_reload is sampled only on the count==1 edge; changing it elsewhere has no effect.
- DONE: count holds 0; leave only via load or reset.
- expired is registered and is 0 in every cycle not listed above.
- running = (state==RUN); done = (state==DONE); both decoded from registered state, not from inputs.
- Arithmetic:
  - Unsigned, DATA_WIDTH bits. Decrement never underflows, because the count==0 path never decrements.
  - The clamp compare is against MAX zero-extended to DATA_WIDTH.
- load_value=0: count=0, state IDLE; a following start is ignored.

Decomposition:
- Package timer_pkg holds:
  - the typedef enum logic [1:0] {IDLE, RUN, DONE} timer_state_t;
  - a localparam helper function clamp_max(value, max) for reuse by the stopwatch family.
- No sub-module is natural; implement as one module with a single state register and next-state/next-count always_comb.

Test Plan:
- reset high 2 cycles -> count=0, running=0, done=0, expired=0.
- load_value=5, load 1 cycle, then start 1 cycle -> count reads 4,3,2,1,0 on successive edges. expired=1 only on the edge where count becomes 0. done=1 after that; running=0.
- load_value=150 with MAX=99 -> count=99; start, then stop after 3 cycles -> count=96 held for 10 cycles; start again -> 95.
- load 3, auto_reload=1, start held 1 cycle -> count 2,1,3,2,1,3. expired pulses on each 1->3 transition; running stays 1, done stays 0.
- start and stop asserted together in IDLE with count=7 -> count stays 7, running=0. Then load and start together with load_value=4 -> count=4, running=0.
- Mid-RUN at count=10: assert reset -> next edge count=0, state IDLE. Then start alone -> ignored, count=0, no expired pulse.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and helpers for the timer/stopwatch family.
package timer_pkg;

    // Controller states shared by the count-down timer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

    // Working width of the clamp helper; wide enough for any counter in the family.
    localparam int CLAMP_W = 64;

    // Saturate a value to an upper bound; callers zero-extend into CLAMP_W bits.
    function automatic logic [CLAMP_W-1:0] clamp_max(
        input logic [CLAMP_W-1:0] value,
        input logic [CLAMP_W-1:0] max
    );
        return (value > max) ? max : value;
    endfunction

endpackage

// File: rtl/countdown_timer.sv
// Count-down timer: loads a clamped preset, decrements once per clock while
// running, pulses expired at the 1->0 (or 1->reload) step, optional auto-reload.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MAX        = 99
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_value,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  auto_reload,
    output logic [DATA_WIDTH-1:0] count,
    output logic                  running,
    output logic                  expired,
    output logic                  done
);

    // MAX as seen by the counter: zero-extended/truncated to the count width.
    localparam logic [DATA_WIDTH-1:0] MAX_W = DATA_WIDTH'(MAX);
    localparam logic [DATA_WIDTH-1:0] ONE_W = DATA_WIDTH'(1);

    timer_state_t          state_reg;
    timer_state_t          state_next;
    logic [DATA_WIDTH-1:0] count_reg;
    logic [DATA_WIDTH-1:0] count_next;
    logic [DATA_WIDTH-1:0] reload_reg;
    logic [DATA_WIDTH-1:0] reload_next;
    logic                  expired_reg;
    logic                  expired_next;

    // Result of one decrement step, used both by RUN and by the start edge.
    timer_state_t          step_state;
    logic [DATA_WIDTH-1:0] step_count;
    logic                  step_expired;

    logic [DATA_WIDTH-1:0] load_clamped;

    assign load_clamped = DATA_WIDTH'(clamp_max(CLAMP_W'(load_value), CLAMP_W'(MAX_W)));

    // One decrement step; at count==1 either expire into DONE or reload and keep running.
    always_comb begin
        step_state   = RUN;
        step_count   = count_reg;
        step_expired = 1'b0;
        if (count_reg > ONE_W) begin
            step_count = count_reg - ONE_W;
        end else if (count_reg == ONE_W) begin
            step_expired = 1'b1;
            if (auto_reload) begin
                step_count = reload_reg;
            end else begin
                step_count = '0;
                step_state = DONE;
            end
        end else begin
            // A zero count never decrements; park in DONE without a pulse.
            step_state = DONE;
        end
    end

    // Next-state logic with priority load > stop > start.
    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        reload_next  = reload_reg;
        expired_next = 1'b0;
        if (load) begin
            count_next  = load_clamped;
            reload_next = load_clamped;
            state_next  = IDLE;
        end else if (stop) begin
            // DONE is only left through load or reset.
            if (state_reg == RUN) begin
                state_next = IDLE;
            end
        end else begin
            unique case (state_reg)
                IDLE: begin
                    // Start decrements on the same edge so there is no dead cycle.
                    if (start && (count_reg != '0)) begin
                        state_next   = step_state;
                        count_next   = step_count;
                        expired_next = step_expired;
                    end
                end
                RUN: begin
                    state_next   = step_state;
                    count_next   = step_count;
                    expired_next = step_expired;
                end
                DONE: begin
                    count_next = '0;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State, count, preset and expiry pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            reload_reg  <= '0;
            expired_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            reload_reg  <= reload_next;
            expired_reg <= expired_next;
        end
    end

    assign count   = count_reg;
    assign expired = expired_reg;
    assign running = (state_reg == RUN);
    assign done    = (state_reg == DONE);

endmodule
